axil_mem_responder: RTL and testbench

AXI-Lite responder (subordinate) that gives the RV core's instruction or data initiator port a byte-addressable word memory in simulation benches and small FPGA builds. It terminates the AW/W/B and AR/R channels with one outstanding write and one outstanding read. Read wait states are configurable, and out-of-range accesses return SLVERR.

---
 rtl/axil_pkg.sv | 22 ++
 rtl/axil_mem_responder_if.sv | 51 +++++
 rtl/axil_mem_array.sv | 32 +++
 rtl/axil_mem_responder.sv | 170 +++++++++++++++++
 tb/tb_axil_mem_responder.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/axil_pkg.sv
// Shared constants and types for the AXI-Lite memory responder.
// Response codes, read FSM states and the word-index width helper.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rd_state_t;

    localparam int DEPTH_WORDS_DEF = 4096;

    function automatic int idx_w(int depth);
        return $clog2(depth);
    endfunction

    localparam int IDX_W_DEF = idx_w(DEPTH_WORDS_DEF);

endpackage

// File: rtl/axil_mem_responder_if.sv
// AXI-Lite bus bundle between an initiator and the memory responder.
// master drives requests; slave drives readys and responses.
interface axil_mem_responder_if #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
);
    logic              aw_valid;
    logic              aw_ready;
    logic [W_ADDR-1:0] aw_addr;
    logic [2:0]        aw_prot;
    logic              w_valid;
    logic              w_ready;
    logic [W_DATA-1:0] w_data;
    logic [3:0]        w_strb;
    logic              b_valid;
    logic              b_ready;
    logic [1:0]        b_resp;
    logic              ar_valid;
    logic              ar_ready;
    logic [W_ADDR-1:0] ar_addr;
    logic [2:0]        ar_prot;
    logic              r_valid;
    logic              r_ready;
    logic [W_DATA-1:0] r_data;
    logic [1:0]        r_resp;

    modport master (
        output aw_valid, aw_addr, aw_prot,
        output w_valid, w_data, w_strb,
        output b_ready,
        output ar_valid, ar_addr, ar_prot,
        output r_ready,
        input  aw_ready, w_ready,
        input  b_valid, b_resp,
        input  ar_ready,
        input  r_valid, r_data, r_resp
    );

    modport slave (
        input  aw_valid, aw_addr, aw_prot,
        input  w_valid, w_data, w_strb,
        input  b_ready,
        input  ar_valid, ar_addr, ar_prot,
        input  r_ready,
        output aw_ready, w_ready,
        output b_valid, b_resp,
        output ar_ready,
        output r_valid, r_data, r_resp
    );

endinterface

// File: rtl/axil_mem_array.sv
// Word memory: one byte-strobed write port, one registered read port.
// A read and write to the same word on one edge returns the old data.
module axil_mem_array #(
    parameter int DEPTH = 4096,
    parameter int IDX_W = 12
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data,
    input  logic [3:0]       wr_strb,
    input  logic             re,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
        if (re) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/axil_mem_responder.sv
// AXI-Lite responder backed by a word memory, one write and one read
// outstanding, configurable read wait states, SLVERR outside the window.
module axil_mem_responder
    import axil_pkg::*;
#(
    parameter int              W_DATA      = 32,
    parameter int              W_ADDR      = 32,
    parameter int              DEPTH_WORDS = 4096,
    parameter logic [W_ADDR-1:0] BASE_ADDR = '0,
    parameter int              READ_WAIT   = 0
) (
    input logic clk,
    input logic reset,
    axil_mem_responder_if.slave bus
);

    localparam int IDX_W = idx_w(DEPTH_WORDS);
    localparam logic [3:0] RW = 4'(READ_WAIT);

    // Extra top bit is the borrow: set when addr < BASE_ADDR.
    logic [W_ADDR:0]  aw_diff, ar_diff;
    logic             aw_ok, ar_ok;
    logic [IDX_W-1:0] aw_idx, ar_idx;

    assign aw_diff = {1'b0, bus.aw_addr} - {1'b0, BASE_ADDR};
    assign ar_diff = {1'b0, bus.ar_addr} - {1'b0, BASE_ADDR};
    assign aw_ok   = !aw_diff[W_ADDR] && (aw_diff[W_ADDR-1:IDX_W+2] == '0);
    assign ar_ok   = !ar_diff[W_ADDR] && (ar_diff[W_ADDR-1:IDX_W+2] == '0);
    assign aw_idx  = aw_diff[IDX_W+1:2];
    assign ar_idx  = ar_diff[IDX_W+1:2];

    logic unused_bits;
    assign unused_bits = ^{bus.aw_prot, bus.ar_prot,
                           aw_diff[1:0], ar_diff[1:0]};

    logic              aw_held, w_held, aw_ok_q;
    logic [IDX_W-1:0]  aw_idx_q;
    logic [W_DATA-1:0] w_data_q;
    logic [3:0]        w_strb_q;
    logic              b_valid_q;
    logic [1:0]        b_resp_q;

    logic              aw_fire, w_fire, commit, wr_ok;
    logic [IDX_W-1:0]  wr_idx;
    logic [W_DATA-1:0] wr_data;
    logic [3:0]        wr_strb;

    assign bus.aw_ready = !aw_held;
    assign bus.w_ready  = !w_held;
    assign bus.b_valid  = b_valid_q;
    assign bus.b_resp   = b_resp_q;

    assign aw_fire = bus.aw_valid && !aw_held;
    assign w_fire  = bus.w_valid && !w_held;
    assign commit  = (aw_held || aw_fire) && (w_held || w_fire)
                  && (!b_valid_q || bus.b_ready);

    assign wr_idx  = aw_held ? aw_idx_q : aw_idx;
    assign wr_ok   = aw_held ? aw_ok_q  : aw_ok;
    assign wr_data = w_held  ? w_data_q : bus.w_data;
    assign wr_strb = w_held  ? w_strb_q : bus.w_strb;

    always_ff @(posedge clk) begin
        if (reset) begin
            aw_held   <= 1'b0;
            aw_idx_q  <= '0;
            aw_ok_q   <= 1'b0;
            w_held    <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_valid_q <= 1'b0;
            b_resp_q  <= RESP_OKAY;
        end else if (commit) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            b_valid_q <= 1'b1;
            b_resp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else begin
            if (aw_fire) begin
                aw_held  <= 1'b1;
                aw_idx_q <= aw_idx;
                aw_ok_q  <= aw_ok;
            end
            if (w_fire) begin
                w_held   <= 1'b1;
                w_data_q <= bus.w_data;
                w_strb_q <= bus.w_strb;
            end
            if (b_valid_q && bus.b_ready) begin
                b_valid_q <= 1'b0;
            end
        end
    end

    rd_state_t        rd_state, rd_state_nxt;
    logic [3:0]       cnt;
    logic [IDX_W-1:0] rd_idx_q, rd_idx;
    logic             rd_ok_q, rd_ok, r_ok, rd_en;
    logic [31:0]      rd_data;

    assign rd_idx = (rd_state == R_IDLE) ? ar_idx : rd_idx_q;
    assign rd_ok  = (rd_state == R_IDLE) ? ar_ok  : rd_ok_q;

    always_comb begin
        rd_state_nxt = rd_state;
        rd_en        = 1'b0;
        unique case (rd_state)
            R_IDLE: begin
                if (bus.ar_valid) begin
                    if (RW == 4'd0) begin
                        rd_state_nxt = R_RESP;
                        rd_en        = 1'b1;
                    end else begin
                        rd_state_nxt = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (cnt == 4'd1) begin
                    rd_state_nxt = R_RESP;
                    rd_en        = 1'b1;
                end
            end
            R_RESP: begin
                if (bus.r_ready) rd_state_nxt = R_IDLE;
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state <= R_IDLE;
            cnt      <= 4'd0;
            rd_idx_q <= '0;
            rd_ok_q  <= 1'b0;
            r_ok     <= 1'b0;
        end else begin
            rd_state <= rd_state_nxt;
            if (rd_state == R_IDLE && bus.ar_valid) begin
                cnt      <= RW;
                rd_idx_q <= ar_idx;
                rd_ok_q  <= ar_ok;
            end else if (rd_state == R_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (rd_en) r_ok <= rd_ok;
        end
    end

    assign bus.ar_ready = (rd_state == R_IDLE);
    assign bus.r_valid  = (rd_state == R_RESP);
    assign bus.r_resp   = (bus.r_valid && !r_ok) ? RESP_SLVERR : RESP_OKAY;
    assign bus.r_data   = (bus.r_valid && r_ok) ? W_DATA'(rd_data) : '0;

    axil_mem_array #(
        .DEPTH (DEPTH_WORDS),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk     (clk),
        .we      (commit && wr_ok),
        .wr_idx  (wr_idx),
        .wr_data (wr_data[31:0]),
        .wr_strb (wr_strb),
        .re      (rd_en),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_axil_mem_responder.sv
// Directed bench: one responder with no read wait, one with three.
// Expected values are hand-computed constants.
module tb_axil_mem_responder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    axil_mem_responder_if #(.W_ADDR(32), .W_DATA(32)) ia ();
    axil_mem_responder_if #(.W_ADDR(32), .W_DATA(32)) ib ();

    axil_mem_responder #(.READ_WAIT(0)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ia.slave)
    );

    axil_mem_responder #(.READ_WAIT(3)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ib.slave)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic wr_a(input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [1:0] resp,
                        input string tag);
        ia.aw_valid = 1'b1;
        ia.aw_addr  = addr;
        ia.w_valid  = 1'b1;
        ia.w_data   = data;
        ia.w_strb   = strb;
        ia.b_ready  = 1'b1;
        tick();
        ia.aw_valid = 1'b0;
        ia.w_valid  = 1'b0;
        chk({tag, "_bvalid"}, 32'(ia.b_valid), 32'd1);
        chk({tag, "_bresp"}, 32'(ia.b_resp), 32'(resp));
        tick();
    endtask

    task automatic rd_a(input logic [31:0] addr, input logic [31:0] data,
                        input logic [1:0] resp, input string tag);
        ia.ar_valid = 1'b1;
        ia.ar_addr  = addr;
        tick();
        ia.ar_valid = 1'b0;
        chk({tag, "_rvalid"}, 32'(ia.r_valid), 32'd1);
        chk({tag, "_rdata"}, ia.r_data, data);
        chk({tag, "_rresp"}, 32'(ia.r_resp), 32'(resp));
        ia.r_ready = 1'b1;
        tick();
        ia.r_ready = 1'b0;
        chk({tag, "_rdone"}, 32'(ia.r_valid), 32'd0);
    endtask

    initial begin
        int n;
        {ia.aw_valid, ia.w_valid, ia.b_ready, ia.ar_valid, ia.r_ready} = '0;
        {ib.aw_valid, ib.w_valid, ib.b_ready, ib.ar_valid, ib.r_ready} = '0;
        ia.aw_addr = '0; ia.aw_prot = '0; ia.w_data = '0; ia.w_strb = '0;
        ia.ar_addr = '0; ia.ar_prot = '0;
        ib.aw_addr = '0; ib.aw_prot = '0; ib.w_data = '0; ib.w_strb = '0;
        ib.ar_addr = '0; ib.ar_prot = '0;

        tick();
        tick();
        chk("rst_awready", 32'(ia.aw_ready), 32'd1);
        chk("rst_wready", 32'(ia.w_ready), 32'd1);
        chk("rst_arready", 32'(ia.ar_ready), 32'd1);
        chk("rst_bvalid", 32'(ia.b_valid), 32'd0);
        chk("rst_rvalid", 32'(ia.r_valid), 32'd0);
        chk("rst_bresp", 32'(ia.b_resp), 32'd0);
        chk("rst_rresp", 32'(ia.r_resp), 32'd0);
        chk("rst_rdata", ia.r_data, 32'd0);
        reset = 1'b0;

        // aligned write/read, single-cycle latency both ways
        wr_a(32'h10, 32'hDEADBEEF, 4'hF, 2'b00, "t1_wr");
        chk("t1_bdone", 32'(ia.b_valid), 32'd0);
        rd_a(32'h10, 32'hDEADBEEF, 2'b00, "t1_rd");
        rd_a(32'h13, 32'hDEADBEEF, 2'b00, "t1_unalign");

        wr_a(32'h20, 32'h11223344, 4'hF, 2'b00, "t2_wr0");
        wr_a(32'h20, 32'hAABBCCDD, 4'b0101, 2'b00, "t2_wr1");
        rd_a(32'h20, 32'h11BB33DD, 2'b00, "t2_rd");
        wr_a(32'h20, 32'hFFFFFFFF, 4'b0000, 2'b00, "t2_wr2");
        rd_a(32'h20, 32'h11BB33DD, 2'b00, "t2_nostrb");

        // AW in cycle 0, W in cycle 5, B held back three cycles
        ia.b_ready  = 1'b0;
        ia.aw_valid = 1'b1;
        ia.aw_addr  = 32'h30;
        tick();
        ia.aw_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            chk($sformatf("t3_awready_c%0d", i), 32'(ia.aw_ready), 32'd0);
            chk($sformatf("t3_bvalid_c%0d", i), 32'(ia.b_valid), 32'd0);
            if (i == 5) begin
                ia.w_valid = 1'b1;
                ia.w_data  = 32'h55667788;
                ia.w_strb  = 4'hF;
            end
            tick();
        end
        ia.w_valid = 1'b0;
        chk("t3_bvalid_c6", 32'(ia.b_valid), 32'd1);
        chk("t3_awready_c6", 32'(ia.aw_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t3_bhold%0d", i), 32'(ia.b_valid), 32'd1);
            chk($sformatf("t3_rhold%0d", i), 32'(ia.b_resp), 32'd0);
        end
        ia.b_ready = 1'b1;
        tick();
        chk("t3_bdone", 32'(ia.b_valid), 32'd0);
        rd_a(32'h30, 32'h55667788, 2'b00, "t3_rd");

        // out of range; 0x4000 would alias word 0 if decode were truncated
        wr_a(32'h0, 32'h01234567, 4'hF, 2'b00, "t4_w0");
        wr_a(32'h4000, 32'hCAFEF00D, 4'hF, 2'b10, "t4_oor_wr");
        rd_a(32'h4000, 32'h0, 2'b10, "t4_oor_rd");
        rd_a(32'h0, 32'h01234567, 2'b00, "t4_w0_rd");
        wr_a(32'h3FFC, 32'h0BADCAFE, 4'hF, 2'b00, "t4_top_wr");
        rd_a(32'h3FFC, 32'h0BADCAFE, 2'b00, "t4_top_rd");

        // READ_WAIT=3 latency and read-before-write collision
        ib.aw_valid = 1'b1; ib.aw_addr = 32'h40;
        ib.w_valid  = 1'b1; ib.w_data  = 32'h0BAD0001; ib.w_strb = 4'hF;
        ib.b_ready  = 1'b1;
        tick();
        ib.aw_valid = 1'b0; ib.w_valid = 1'b0;
        tick();
        ib.ar_valid = 1'b1; ib.ar_addr = 32'h40;
        tick();
        ib.ar_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("t5_rvalid_n%0d", i), 32'(ib.r_valid), 32'd0);
            if (i == 3) begin
                ib.aw_valid = 1'b1; ib.aw_addr = 32'h40;
                ib.w_valid  = 1'b1; ib.w_data  = 32'h0BAD0002;
            end
            tick();
        end
        ib.aw_valid = 1'b0; ib.w_valid = 1'b0;
        chk("t5_rvalid_n4", 32'(ib.r_valid), 32'd1);
        chk("t5_rdata_old", ib.r_data, 32'h0BAD0001);
        chk("t5_bvalid", 32'(ib.b_valid), 32'd1);
        ib.r_ready = 1'b1;
        tick();
        ib.r_ready = 1'b0;
        ib.ar_valid = 1'b1;
        tick();
        ib.ar_valid = 1'b0;
        n = 0;
        while (!ib.r_valid && n < 20) begin
            tick();
            n++;
        end
        chk("t5_rd2_valid", 32'(ib.r_valid), 32'd1);
        chk("t5_rd2_wait", 32'(n), 32'd3);
        chk("t5_rdata_new", ib.r_data, 32'h0BAD0002);
        ib.r_ready = 1'b1;
        tick();
        ib.r_ready = 1'b0;

        // reset with a read response pending and AW held
        ia.b_ready  = 1'b0;
        ia.ar_valid = 1'b1; ia.ar_addr = 32'h10;
        ia.aw_valid = 1'b1; ia.aw_addr = 32'h50;
        tick();
        ia.ar_valid = 1'b0; ia.aw_valid = 1'b0;
        chk("t6_pre_rvalid", 32'(ia.r_valid), 32'd1);
        chk("t6_pre_awready", 32'(ia.aw_ready), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rvalid", 32'(ia.r_valid), 32'd0);
        chk("t6_bvalid", 32'(ia.b_valid), 32'd0);
        chk("t6_awready", 32'(ia.aw_ready), 32'd1);
        chk("t6_wready", 32'(ia.w_ready), 32'd1);
        chk("t6_arready", 32'(ia.ar_ready), 32'd1);
        ia.b_ready = 1'b1;
        ia.w_valid = 1'b1; ia.w_data = 32'h12345678; ia.w_strb = 4'hF;
        tick();
        ia.w_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t6_nostale%0d", i), 32'(ia.b_valid), 32'd0);
            tick();
        end
        chk("t6_wheld", 32'(ia.w_ready), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
